// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-flop synchronizer, 4-state debounce FSM, stability counter.
// Ports: clk_i, rst_i (async high), btn_i raw; level_o, rise_o, fall_o, busy_o registered.
module btn_debounce_pulse #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 19
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 busy_q, busy_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    endcase
    // busy tracks the state being entered so it lines up with state_q
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse with STABLE_CYCLES=8, CNT_WIDTH=4.
// Per-cycle vectors feed a scoreboard queue; reset corners are hand-written.
module tb_btn_debounce_pulse;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic btn_i = 1'b0;
  logic level_o, rise_o, fall_o, busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic btn;
    logic level;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  btn_debounce_pulse #(
    .STABLE_CYCLES(8),
    .CNT_WIDTH(4)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_i),
    .level_o(level_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic act,
                     input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic l,
                         input logic r, input logic f,
                         input logic b);
    chk({tag, ".level"}, level_o, l);
    chk({tag, ".rise"}, rise_o, r);
    chk({tag, ".fall"}, fall_o, f);
    chk({tag, ".busy"}, busy_o, b);
  endtask

  // n cycles driving btn, each expecting the given outputs after the edge
  task automatic add(input int n, input logic btn, input logic l,
                     input logic r, input logic f, input logic b);
    vec_t v;
    v.btn = btn;
    v.level = l;
    v.rise = r;
    v.fall = f;
    v.busy = b;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic run(input string tag);
    vec_t v, e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      btn_i = vecs[i].btn;
      sb.push_back(vecs[i]);
      @(posedge clk_i);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: scoreboard empty", tag);
      end else begin
        e = sb.pop_front();
        chk_all($sformatf("%s[%0d]", tag, i),
                e.level, e.rise, e.fall, e.busy);
      end
    end
    vecs.delete();
  endtask

  task automatic press();
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic release_btn();
    add(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // async reset with button held, before any clock edge
    #1;
    btn_i = 1'b1;
    rst_i = 1'b1;
    #1;
    chk_all("rst_noclk", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    chk_all("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    btn_i = 1'b0;
    rst_i = 1'b0;

    add(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run("idle");

    press();
    run("press");

    release_btn();
    run("release");

    press();
    run("press2");

    // one-cycle low glitch while high
    add(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run("glitch");

    release_btn();
    run("release2");

    // bouncy press: 5 high, 2 low, then steady high
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run("bounce");

    release_btn();
    run("release3");

    // reset arriving in WAIT_HIGH with the counter at 5
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run("prewait");
    #2;
    rst_i = 1'b1;
    #1;
    chk_all("rst_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk_i);
      #1;
      chk_all("rst_wait_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run("post_rst");

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: left %0d want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
